// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
//   Match sequencer for the 8-LED ping-pong game. Releases the ball by driving
//   the LED mover's game_start, watches its LED bus to judge hits and misses
//   at each end, keeps both scores and declares the winner.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active low
//   i_tick       in   1  1 ms strobe, one clk wide
//   i_start      in   1  start-match pulse
//   i_btn_l/r    in   1  debounced player hit pulses
//   i_led        in   8  LED mover bus (bit0 = left end, bit7 = right end)
//   o_game_start out  1  high only in PLAY
//   o_game_over  out  1  high only in OVER
//   o_score_l/r  out  4  scores
//   o_winner     out  2  00 none, 01 left, 10 right
//   o_hit        out  1  one-clk pulse per judged hit
//   o_state      out  3  IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
// ---------------------------------------------------------------------------
module game_flow_ctrl #(
    parameter int WIN_SCORE = 5,
    parameter int SERVE_MS  = 500,
    parameter int POINT_MS  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_start,
    input  logic       i_btn_l,
    input  logic       i_btn_r,
    input  logic [7:0] i_led,
    output logic       o_game_start,
    output logic       o_game_over,
    output logic [3:0] o_score_l,
    output logic [3:0] o_score_r,
    output logic [1:0] o_winner,
    output logic       o_hit,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_e;

    state_e      state_q;
    logic [15:0] timer_q;
    logic [7:0]  led_prev_q;
    logic [3:0]  score_l_q, score_r_q;
    logic [1:0]  winner_q;
    logic        hit_l_q, hit_r_q, serve_armed_q;
    logic        game_start_q, game_over_q, hit_pulse_q;

    // A window is open while the end LED is lit; it closes on the falling
    // edge of that LED. A press in the closing cycle still sees led_prev lit,
    // so it counts as a hit.
    logic close_r, close_l, press_r, press_l, miss_r, miss_l;
    logic serve_done, point_done;
    logic [3:0] score_l_inc, score_r_inc;

    assign close_r = led_prev_q[7] & ~i_led[7];
    assign close_l = led_prev_q[0] & ~i_led[0];
    assign press_r = i_btn_r & (i_led[7] | led_prev_q[7]);
    // The serve visit to bit0 is not judged at all.
    assign press_l = i_btn_l & (i_led[0] | led_prev_q[0]) & ~serve_armed_q;
    assign miss_r  = close_r & ~hit_r_q & ~press_r;
    assign miss_l  = close_l & ~serve_armed_q & ~hit_l_q & ~press_l;

    assign serve_done  = i_tick && (timer_q == 16'(SERVE_MS - 1));
    assign point_done  = i_tick && (timer_q == 16'(POINT_MS - 1));
    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            led_prev_q    <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            winner_q      <= '0;
            hit_l_q       <= 1'b0;
            hit_r_q       <= 1'b0;
            serve_armed_q <= 1'b0;
            game_start_q  <= 1'b0;
            game_over_q   <= 1'b0;
            hit_pulse_q   <= 1'b0;
        end else begin
            led_prev_q  <= i_led;
            hit_pulse_q <= 1'b0;
            if (i_tick) timer_q <= timer_q + 16'd1;

            case (state_q)
                IDLE, OVER: begin
                    if (i_start) begin
                        state_q     <= SERVE;
                        timer_q     <= '0;
                        score_l_q   <= '0;
                        score_r_q   <= '0;
                        winner_q    <= '0;
                        game_over_q <= 1'b0;
                    end
                end
                SERVE: begin
                    if (serve_done) begin
                        state_q       <= PLAY;
                        timer_q       <= '0;
                        game_start_q  <= 1'b1;
                        serve_armed_q <= 1'b1;
                        hit_l_q       <= 1'b0;
                        hit_r_q       <= 1'b0;
                    end
                end
                PLAY: begin
                    hit_pulse_q <= (press_r & ~hit_r_q) | (press_l & ~hit_l_q);
                    if (press_r) hit_r_q <= 1'b1;
                    if (press_l) hit_l_q <= 1'b1;
                    // Later assignments win: every close clears its flag.
                    if (close_r) hit_r_q <= 1'b0;
                    if (close_l) begin
                        hit_l_q       <= 1'b0;
                        serve_armed_q <= 1'b0;
                    end
                    if (miss_r || miss_l) begin
                        state_q      <= POINT;
                        timer_q      <= '0;
                        game_start_q <= 1'b0;
                    end
                    if (miss_r) begin
                        score_l_q <= score_l_inc;
                        if (score_l_inc == 4'(WIN_SCORE)) winner_q <= 2'b01;
                    end else if (miss_l) begin
                        score_r_q <= score_r_inc;
                        if (score_r_inc == 4'(WIN_SCORE)) winner_q <= 2'b10;
                    end
                end
                POINT: begin
                    if (point_done) begin
                        timer_q <= '0;
                        if (score_l_q == 4'(WIN_SCORE) || score_r_q == 4'(WIN_SCORE)) begin
                            state_q     <= OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q <= SERVE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_game_start = game_start_q;
    assign o_game_over  = game_over_q;
    assign o_score_l    = score_l_q;
    assign o_score_r    = score_r_q;
    assign o_winner     = winner_q;
    assign o_hit        = hit_pulse_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: the LED bus is driven by hand to mimic
// the ball mover, ticks are issued one at a time.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst, i_tick, i_start, i_btn_l, i_btn_r;
    logic [7:0] i_led;
    logic       o_game_start, o_game_over, o_hit;
    logic [3:0] o_score_l, o_score_r;
    logic [1:0] o_winner;
    logic [2:0] o_state;

    int n_cmp = 0;
    int n_err = 0;

    game_flow_ctrl #(.WIN_SCORE(2), .SERVE_MS(2), .POINT_MS(3)) dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_start(i_start),
        .i_btn_l(i_btn_l), .i_btn_r(i_btn_r), .i_led(i_led),
        .o_game_start(o_game_start), .o_game_over(o_game_over),
        .o_score_l(o_score_l), .o_score_r(o_score_r), .o_winner(o_winner),
        .o_hit(o_hit), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        i_tick = 1'b1; cyc(); i_tick = 1'b0;
    endtask

    task automatic set_led_cyc(input logic [7:0] v);
        i_led = v; cyc();
    endtask

    initial begin
        rst = 1'b0; i_tick = 1'b0; i_start = 1'b1;
        i_btn_l = 1'b0; i_btn_r = 1'b0; i_led = 8'h00;
        // 1: reset beats start
        cyc(); cyc();
        chk("rst_state", 16'(o_state), 16'd0);
        chk("rst_gs", 16'(o_game_start), 16'd0);
        chk("rst_go", 16'(o_game_over), 16'd0);
        chk("rst_scores", {8'h0, o_score_l, o_score_r}, 16'h0);
        chk("rst_win_hit", {13'h0, o_winner, o_hit}, 16'h0);
        rst = 1'b1; i_start = 1'b0; cyc();
        chk("idle_hold", 16'(o_state), 16'd0);
        i_start = 1'b1; cyc(); i_start = 1'b0;
        chk("start_serve", 16'(o_state), 16'd1);
        tick();
        chk("serve_tick1", 16'(o_state), 16'd1);
        tick();
        chk("serve_tick2_play", 16'(o_state), 16'd2);
        chk("play_gs", 16'(o_game_start), 16'd1);

        // 2: right hit, then left miss after serve visit is spent
        set_led_cyc(8'h01); cyc();
        set_led_cyc(8'h02);
        chk("serve_visit_free", {8'h0, o_score_l, o_score_r}, 16'h00);
        set_led_cyc(8'h80);
        i_btn_r = 1'b1; cyc(); i_btn_r = 1'b0;
        chk("hit_r_pulse", 16'(o_hit), 16'd1);
        cyc();
        chk("hit_r_one_clk", 16'(o_hit), 16'd0);
        i_btn_r = 1'b1; cyc(); i_btn_r = 1'b0;
        chk("hit_r_repress", 16'(o_hit), 16'd0);
        set_led_cyc(8'h40);
        chk("hit_r_noscore", {8'h0, o_score_l, o_score_r}, 16'h00);
        chk("hit_r_still_play", 16'(o_state), 16'd2);
        set_led_cyc(8'h01); cyc();
        set_led_cyc(8'h02);
        chk("miss_l_score_r", {8'h0, o_score_l, o_score_r}, 16'h01);
        chk("miss_l_point", 16'(o_state), 16'd3);
        chk("miss_l_gs", 16'(o_game_start), 16'd0);

        // 3: right miss, point pause length
        i_led = 8'h01;
        tick(); tick();
        chk("point_2ticks", 16'(o_state), 16'd3);
        tick();
        chk("point_3ticks", 16'(o_state), 16'd1);
        tick(); tick();
        chk("play2", 16'(o_state), 16'd2);
        set_led_cyc(8'h02);
        set_led_cyc(8'h80); cyc();
        set_led_cyc(8'h40);
        chk("miss_r_score_l", {8'h0, o_score_l, o_score_r}, 16'h11);
        chk("miss_r_point", 16'(o_state), 16'd3);
        tick(); tick(); tick(); tick(); tick();
        chk("play3", 16'(o_state), 16'd2);

        // 4: early press ignored, winning point
        set_led_cyc(8'h01);
        set_led_cyc(8'h02);
        i_led = 8'h10; i_btn_r = 1'b1; cyc(); i_btn_r = 1'b0;
        chk("early_press_nohit", 16'(o_hit), 16'd0);
        set_led_cyc(8'h80); cyc();
        set_led_cyc(8'h40);
        chk("win_score_l", 16'(o_score_l), 16'd2);
        chk("win_winner", 16'(o_winner), 16'd1);
        chk("win_point", 16'(o_state), 16'd3);

        // 5: start ignored in POINT, OVER, restart clears
        i_start = 1'b1; cyc(); i_start = 1'b0;
        chk("start_ign_point", 16'(o_state), 16'd3);
        tick(); tick(); tick();
        chk("over_state", 16'(o_state), 16'd4);
        chk("over_go", 16'(o_game_over), 16'd1);
        chk("over_held", {6'h0, o_winner, o_score_l, o_score_r}, 16'h0121);
        i_start = 1'b1; cyc(); i_start = 1'b0;
        chk("restart_state", 16'(o_state), 16'd1);
        chk("restart_clear", {6'h0, o_winner, o_score_l, o_score_r}, 16'h0000);
        chk("restart_go", 16'(o_game_over), 16'd0);

        // 6: press on close counts, both buttons, then reset mid-PLAY
        tick(); tick();
        set_led_cyc(8'h01);
        set_led_cyc(8'h02);
        set_led_cyc(8'h80);
        i_led = 8'h40; i_btn_r = 1'b1; cyc(); i_btn_r = 1'b0;
        chk("close_press_hit", 16'(o_hit), 16'd1);
        chk("close_press_noscore", {8'h0, o_score_l, o_score_r}, 16'h00);
        set_led_cyc(8'h01);
        i_btn_l = 1'b1; i_btn_r = 1'b1; cyc(); i_btn_l = 1'b0; i_btn_r = 1'b0;
        chk("both_btn_hit", 16'(o_hit), 16'd1);
        set_led_cyc(8'h02);
        chk("both_btn_noscore", {8'h0, o_score_l, o_score_r}, 16'h00);
        chk("both_btn_play", 16'(o_state), 16'd2);
        set_led_cyc(8'h80);
        set_led_cyc(8'h40);
        chk("miss_r2", 16'(o_score_l), 16'd1);
        tick(); tick(); tick(); tick(); tick();
        chk("play_again", 16'(o_state), 16'd2);
        set_led_cyc(8'h20);
        rst = 1'b0; cyc(); rst = 1'b1;
        chk("midplay_rst_state", 16'(o_state), 16'd0);
        chk("midplay_rst_scores", {8'h0, o_score_l, o_score_r}, 16'h00);
        chk("midplay_rst_gs", 16'(o_game_start), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
